fifo_vr: RTL and testbench

- Parametrised synchronous FIFO with valid/ready handshake on both sides. Successor to the single-stage pass-through fifo.
- Adds configurable data width and depth, real storage, an occupancy count, an almost-full flag, and an optional same-cycle bypass mode.
- Sits between a valid/ready producer and consumer in the datapath. Decouples stalls by up to DEPTH entries.

---
 rtl/fifo_vr.sv | 86 ++++++++
 tb/tb_fifo_vr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_vr.sv
// Parametrised synchronous FIFO with valid/ready on both sides, occupancy count,
// almost-full flag and optional same-cycle bypass when empty.
module fifo_vr #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned AFULL_LVL = DEPTH - 1,
  parameter int unsigned BYPASS    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pvld,
  input  logic [WIDTH-1:0] in_pd,
  output logic             in_prdy,
  output logic             o_pvld,
  output logic [WIDTH-1:0] o_pd,
  input  logic             o_prdy,
  output logic [AW:0]      count,
  output logic             afull
);

  if ((WIDTH < 1) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AW != $clog2(DEPTH)) || (AFULL_LVL < 1) || (AFULL_LVL > DEPTH)) begin : g_bad_params
    $error("fifo_vr: illegal parameters (DEPTH must be a power of 2 >= 2, AFULL_LVL in 1..DEPTH)");
  end

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty, push, pop, bypass_take, wr_en, rd_en;

  // Handshake, output selection and next-state; all flags depend on registered count only
  always_comb begin
    empty       = (count_q == '0);
    in_prdy     = (count_q != FULL_CNT);
    afull       = (count_q >= AFULL_CNT);
    count       = count_q;
    o_pvld      = 1'b0;
    o_pd        = '0;
    if (!empty) begin
      o_pvld = 1'b1;
      o_pd   = mem_q[rd_ptr_q];
    end else if (BYPASS != 0) begin
      o_pvld = in_pvld;
      o_pd   = in_pvld ? in_pd : '0;
    end
    push        = in_pvld & in_prdy;
    pop         = o_pvld & o_prdy;
    // A pop while empty can only be a bypassed beat: it never touches storage
    bypass_take = empty & push & pop;
    wr_en       = push & ~bypass_take;
    rd_en       = pop & ~empty;
    wr_ptr_d    = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + (AW+1)'(1);
    end else if (rd_en && !wr_en) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem_q[wr_ptr_q] <= in_pd;
    end
  end

endmodule

// File: tb/tb_fifo_vr.sv
// Self-checking bench for fifo_vr: directed scenarios plus a random run against
// a queue-based reference model (one instance without bypass, one with).
module tb_fifo_vr;

  localparam int unsigned D   = 4;
  localparam int unsigned AFL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_pvld;
  logic [7:0] in_pd;
  logic       o_prdy;
  logic       in_prdy0, o_pvld0, afull0;
  logic [7:0] o_pd0;
  logic [2:0] count0;
  logic       in_prdy1, o_pvld1, afull1;
  logic [7:0] o_pd1;
  logic [2:0] count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_vr #(.WIDTH(8), .DEPTH(D), .AFULL_LVL(AFL), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .in_pvld(in_pvld), .in_pd(in_pd), .in_prdy(in_prdy0),
    .o_pvld(o_pvld0), .o_pd(o_pd0), .o_prdy(o_prdy), .count(count0), .afull(afull0)
  );

  fifo_vr #(.WIDTH(8), .DEPTH(D), .AFULL_LVL(AFL), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst), .in_pvld(in_pvld), .in_pd(in_pd), .in_prdy(in_prdy1),
    .o_pvld(o_pvld1), .o_pd(o_pd1), .o_prdy(o_prdy), .count(count1), .afull(afull1)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_pvld = 1'b0; in_pd = '0; o_prdy = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_pvld = 1'b0; in_pd = '0; o_prdy = 1'b0; rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (o_pvld0 !== 1'b0) begin errors++; $display("FAIL reset_o_pvld got %b exp 0", o_pvld0); end
    checks++; if (o_pd0 !== 8'h00) begin errors++; $display("FAIL reset_o_pd got %h exp 00", o_pd0); end
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count0); end
    checks++; if (in_prdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_prdy got %b exp 1", in_prdy0); end
    checks++; if (afull0 !== 1'b0) begin errors++; $display("FAIL reset_afull got %b exp 0", afull0); end
    checks++; if (o_pvld1 !== 1'b0 || count1 !== 3'd0) begin errors++; $display("FAIL reset_byp got vld %b cnt %0d exp 0 0", o_pvld1, count1); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [2:0] ecnt;
    in_pvld = 1'b1; o_prdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_pd = 8'(17 * (i + 1));
      next_cycle();
      ecnt = 3'(i + 1);
      checks++; if (count0 !== ecnt) begin errors++; $display("FAIL fill_count got %0d exp %0d", count0, ecnt); end
      checks++; if (afull0 !== (ecnt >= 3'(AFL))) begin errors++; $display("FAIL fill_afull got %b at count %0d", afull0, ecnt); end
      checks++; if (o_pvld0 !== 1'b1 || o_pd0 !== 8'h11) begin errors++; $display("FAIL fill_head got %b/%h exp 1/11", o_pvld0, o_pd0); end
    end
    checks++; if (in_prdy0 !== 1'b0) begin errors++; $display("FAIL fill_in_prdy got %b exp 0", in_prdy0); end
    in_pd = 8'h55;
    next_cycle();
    checks++; if (count0 !== 3'd4 || o_pd0 !== 8'h11) begin errors++; $display("FAIL fill_held got cnt %0d pd %h exp 4 11", count0, o_pd0); end
  endtask

  task automatic test_drain_wrap();
    int idx = 0;
    int got = 0;
    logic push;
    logic [7:0] exp_pd;
    o_prdy = 1'b1;
    checks++; if (in_prdy0 !== 1'b0) begin errors++; $display("FAIL drain_full_rdy got %b exp 0", in_prdy0); end
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_pvld = (idx < 4);
      in_pd   = 8'(8'h55 + idx);
      push    = in_pvld & in_prdy0;
      if (o_pvld0 && o_prdy) begin
        exp_pd = (got < 4) ? 8'(17 * (got + 1)) : 8'(8'h55 + got - 4);
        checks++; if (o_pd0 !== exp_pd) begin errors++; $display("FAIL drain_data got %h exp %h", o_pd0, exp_pd); end
        got++;
      end
      next_cycle();
      if (push) idx++;
    end
    in_pvld = 1'b0;
    checks++; if (got != 8) begin errors++; $display("FAIL drain_timeout got %0d beats exp 8", got); end
    checks++; if (count0 !== 3'd0 || o_pvld0 !== 1'b0) begin errors++; $display("FAIL drain_empty got cnt %0d vld %b exp 0 0", count0, o_pvld0); end
  endtask

  task automatic test_stream();
    o_prdy = 1'b0; in_pvld = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_pd = 8'(i);
      next_cycle();
    end
    o_prdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pd = 8'(i + 2);
      checks++; if (o_pvld0 !== 1'b1 || o_pd0 !== 8'(i)) begin errors++; $display("FAIL stream_lag got %b/%h exp 1/%h", o_pvld0, o_pd0, 8'(i)); end
      next_cycle();
      checks++; if (count0 !== 3'd2) begin errors++; $display("FAIL stream_count got %0d exp 2", count0); end
    end
    in_pvld = 1'b0;
    next_cycle();
    next_cycle();
    o_prdy = 1'b0;
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL stream_drain got %0d exp 0", count0); end
  endtask

  task automatic test_bypass();
    do_reset();
    in_pvld = 1'b1; in_pd = 8'hA5; o_prdy = 1'b1;
    #1;
    checks++; if (o_pvld1 !== 1'b1 || o_pd1 !== 8'hA5) begin errors++; $display("FAIL byp_same_cycle got %b/%h exp 1/a5", o_pvld1, o_pd1); end
    checks++; if (o_pvld0 !== 1'b0 || o_pd0 !== 8'h00) begin errors++; $display("FAIL nobyp_empty got %b/%h exp 0/00", o_pvld0, o_pd0); end
    next_cycle();
    checks++; if (count1 !== 3'd0) begin errors++; $display("FAIL byp_consumed_count got %0d exp 0", count1); end
    o_prdy = 1'b0;
    #1;
    checks++; if (o_pvld1 !== 1'b1 || o_pd1 !== 8'hA5) begin errors++; $display("FAIL byp_stall_present got %b/%h exp 1/a5", o_pvld1, o_pd1); end
    next_cycle();
    in_pvld = 1'b0; in_pd = 8'h00;
    #1;
    checks++; if (count1 !== 3'd1 || o_pvld1 !== 1'b1 || o_pd1 !== 8'hA5) begin errors++; $display("FAIL byp_stored got cnt %0d %b/%h exp 1 1/a5", count1, o_pvld1, o_pd1); end
    next_cycle();
    checks++; if (o_pd1 !== 8'hA5) begin errors++; $display("FAIL byp_hold got %h exp a5", o_pd1); end
    o_prdy = 1'b1;
    next_cycle();
    o_prdy = 1'b0;
    checks++; if (count1 !== 3'd0 || o_pvld1 !== 1'b0 || o_pd1 !== 8'h00) begin errors++; $display("FAIL byp_popped got cnt %0d %b/%h exp 0 0/00", count1, o_pvld1, o_pd1); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    o_prdy = 1'b0; in_pvld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pd = 8'(8'h31 + i);
      next_cycle();
    end
    in_pvld = 1'b0;
    checks++; if (count0 !== 3'd3) begin errors++; $display("FAIL mid_prefill got %0d exp 3", count0); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count0 !== 3'd0 || o_pvld0 !== 1'b0 || in_prdy0 !== 1'b1) begin errors++; $display("FAIL mid_async got cnt %0d vld %b rdy %b exp 0 0 1", count0, o_pvld0, in_prdy0); end
    next_cycle();
    rst = 1'b0; in_pvld = 1'b1; in_pd = 8'h7E;
    checks++; if (o_pvld0 !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b exp 0", o_pvld0); end
    next_cycle();
    in_pvld = 1'b0;
    checks++; if (o_pvld0 !== 1'b1 || o_pd0 !== 8'h7E || count0 !== 3'd1) begin errors++; $display("FAIL mid_first_push got %b/%h cnt %0d exp 1/7e 1", o_pvld0, o_pd0, count0); end
  endtask

  task automatic test_random();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       e_vld, e_rdy, e_af, push, pop;
    logic [7:0] e_pd;
    logic [2:0] e_cnt;
    int         pr;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      pr      = ((n / 100) % 2 == 0) ? 30 : 85;
      in_pvld = ($urandom_range(0, 99) < 65);
      in_pd   = 8'($urandom);
      o_prdy  = ($urandom_range(0, 99) < pr);
      #1;
      // instance without bypass
      e_vld = (q0.size() != 0);
      e_pd  = e_vld ? q0[0] : 8'h00;
      e_rdy = (q0.size() < D);
      e_cnt = 3'(q0.size());
      e_af  = (q0.size() >= AFL);
      checks++; if (o_pvld0 !== e_vld) begin errors++; $display("FAIL rnd0_o_pvld n=%0d got %b exp %b", n, o_pvld0, e_vld); end
      checks++; if (o_pd0 !== e_pd) begin errors++; $display("FAIL rnd0_o_pd n=%0d got %h exp %h", n, o_pd0, e_pd); end
      checks++; if (in_prdy0 !== e_rdy) begin errors++; $display("FAIL rnd0_in_prdy n=%0d got %b exp %b", n, in_prdy0, e_rdy); end
      checks++; if (count0 !== e_cnt) begin errors++; $display("FAIL rnd0_count n=%0d got %0d exp %0d", n, count0, e_cnt); end
      checks++; if (afull0 !== e_af) begin errors++; $display("FAIL rnd0_afull n=%0d got %b exp %b", n, afull0, e_af); end
      push = in_pvld && e_rdy;
      pop  = e_vld && o_prdy;
      if (pop) void'(q0.pop_front());
      if (push) q0.push_back(in_pd);
      // instance with bypass
      if (q1.size() == 0) begin
        e_vld = in_pvld;
        e_pd  = in_pvld ? in_pd : 8'h00;
      end else begin
        e_vld = 1'b1;
        e_pd  = q1[0];
      end
      e_rdy = (q1.size() < D);
      e_cnt = 3'(q1.size());
      e_af  = (q1.size() >= AFL);
      checks++; if (o_pvld1 !== e_vld) begin errors++; $display("FAIL rnd1_o_pvld n=%0d got %b exp %b", n, o_pvld1, e_vld); end
      checks++; if (o_pd1 !== e_pd) begin errors++; $display("FAIL rnd1_o_pd n=%0d got %h exp %h", n, o_pd1, e_pd); end
      checks++; if (in_prdy1 !== e_rdy) begin errors++; $display("FAIL rnd1_in_prdy n=%0d got %b exp %b", n, in_prdy1, e_rdy); end
      checks++; if (count1 !== e_cnt) begin errors++; $display("FAIL rnd1_count n=%0d got %0d exp %0d", n, count1, e_cnt); end
      checks++; if (afull1 !== e_af) begin errors++; $display("FAIL rnd1_afull n=%0d got %b exp %b", n, afull1, e_af); end
      push = in_pvld && e_rdy;
      pop  = e_vld && o_prdy;
      if (!(q1.size() == 0 && push && pop)) begin
        if (pop) void'(q1.pop_front());
        if (push) q1.push_back(in_pd);
      end
      @(posedge clk);
      #1;
    end
    in_pvld = 1'b0; o_prdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_wrap();
    test_stream();
    test_bypass();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
